// File: rtl/inst_issue_sequencer.sv
// inst_issue_sequencer: instruction FIFO that presents each queued word on inst for SLOT_CYCLES cycles.
module inst_issue_sequencer #(
   parameter int DEPTH = 8,
   parameter int SLOT_CYCLES = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_inst,
   input  logic        flush,
   output logic [31:0] inst,
   output logic [1:0]  slot_phase,
   output logic [AW:0] level,
   output logic [15:0] issued_cnt,
   output logic        busy
);
   typedef enum logic {IDLE, SLOT} state_t;
   state_t r_state, w_next;
   logic [31:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0] r_level;
   logic [31:0] r_inst;
   logic [1:0] r_phase;
   logic [15:0] r_cnt;
   logic w_push, w_pop, w_last;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;

   always_comb
      w_next = flush ? IDLE : (r_state == IDLE || w_last) ? (r_level != '0 ? SLOT : IDLE) : SLOT;

   always_comb begin
      w_last = r_state == SLOT && r_phase == 2'(SLOT_CYCLES - 1);
      wr_ready = r_level != (AW+1)'(DEPTH) && !flush;
      w_push = wr_valid && wr_ready && wr_inst[6:0] != 7'd0;
      w_pop = !flush && (r_state == IDLE || w_last) && r_level != '0;
      busy = r_state == SLOT || r_level != '0;
      inst = r_inst;
      slot_phase = r_phase;
      level = r_level;
      issued_cnt = r_cnt;
   end

   // pops happen only at slot start; a slot ending with an empty queue drops inst to zero
   always_ff @(posedge clk or posedge rst)
      if (rst || flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_level <= '0;
         r_inst <= '0;
         r_phase <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_inst <= w_pop ? r_mem[r_rptr] : w_last ? '0 : r_inst;
         r_phase <= (r_state == SLOT && !w_last) ? r_phase + 2'd1 : 2'd0;
         r_cnt <= r_cnt + 16'(w_pop);
      end

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= wr_inst;
endmodule

// File: tb/tb_inst_issue_sequencer.sv
// tb_inst_issue_sequencer: random and directed stimulus against a queue-based issue model with a scoreboard monitor.
module tb_inst_issue_sequencer;
   localparam int DEPTH = 8;
   localparam int SC = 4;
   logic clk = 0, rst = 1, wr_valid = 0, flush = 0;
   logic [31:0] wr_inst = 0;
   logic wr_ready, busy;
   logic [31:0] inst;
   logic [1:0] slot_phase;
   logic [3:0] level;
   logic [15:0] issued_cnt;
   int n_vec = 0, n_bad = 0;

   logic [31:0] mq[$];
   logic [31:0] exp_q[$];
   int left = 0, m_phase = 0;
   logic [31:0] m_inst = 0;
   logic [15:0] m_cnt = 0;
   logic [15:0] prev_cnt = 0;

   inst_issue_sequencer #(.DEPTH(DEPTH), .SLOT_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_inst(wr_inst),
      .flush(flush), .inst(inst), .slot_phase(slot_phase), .level(level),
      .issued_cnt(issued_cnt), .busy(busy));

   always #5 clk = ~clk;

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      left = 0;
      m_phase = 0;
      m_inst = 0;
      m_cnt = 0;
   endtask

   // left = cycles remaining in current slot, 0 when nothing is being presented
   task automatic model_step(input logic v, input logic [31:0] w, input logic f);
      bit pop, push;
      if (f) begin
         model_reset();
         return;
      end
      pop = left <= 1 && mq.size() > 0;
      push = v && mq.size() != DEPTH && w[6:0] != 0;
      if (pop) begin
         m_inst = mq.pop_front();
         left = SC;
         m_phase = 0;
         m_cnt++;
         exp_q.push_back(m_inst);
      end else if (left == 1) begin
         m_inst = 0;
         left = 0;
         m_phase = 0;
      end else if (left > 1) begin
         left--;
         m_phase++;
      end
      if (push) mq.push_back(w);
   endtask

   task automatic cycle(input logic v, input logic [31:0] w, input logic f);
      wr_valid = v;
      wr_inst = w;
      flush = f;
      @(posedge clk);
      model_step(v, w, f);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0);
   endtask

   task automatic async_reset();
      #2;
      rst = 1;
      wr_valid = 0;
      flush = 0;
      #1;
      check("rst_inst", inst, 0);
      check("rst_level", 32'(level), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(wr_ready), 1);
      check("rst_cnt", 32'(issued_cnt), 0);
      check("rst_phase", 32'(slot_phase), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("inst", inst, m_inst);
         check("slot_phase", 32'(slot_phase), 32'(m_phase));
         check("level", 32'(level), 32'(mq.size()));
         check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
         check("busy", 32'(busy), 32'(left > 0 || mq.size() > 0));
         check("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH && !flush));
         if (issued_cnt == 16'(prev_cnt + 16'd1)) begin
            if (exp_q.size() == 0) check("issue_unexpected", inst, 32'hxxxxxxxx);
            else check("issue_order", inst, exp_q.pop_front());
         end
      end
      prev_cnt = issued_cnt;
   end

   initial begin
      #1;
      check("por_inst", inst, 0);
      check("por_level", 32'(level), 0);
      check("por_ready", 32'(wr_ready), 1);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      cycle(1, 32'h2, 0);
      idle(8);
      for (int i = 0; i < 3; i++) cycle(1, 32'h33 | (i << 7), 0);
      idle(16);
      for (int i = 0; i < 14; i++) cycle(1, 32'h13 | (i << 12), 0);
      idle(45);
      cycle(1, 32'h0, 0);
      idle(2);
      for (int i = 0; i < 4; i++) cycle(1, 32'h37 | (i << 20), 0);
      idle(3);
      cycle(1, 32'h6f, 1);
      idle(3);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(7) == 0) w[6:0] = 0;
         cycle($urandom_range(2) != 0, w, $urandom_range(39) == 0);
      end
      idle(40);
      for (int i = 0; i < 4; i++) cycle(1, 32'h23 | (i << 8), 0);
      idle(1);
      async_reset();
      cycle(1, 32'hABCD0003, 0);
      idle(8);
      check("scoreboard_drain", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
